// File: rtl/conv2d_loader_pkg.sv
// Shared types and constants for the conv2d frame loader.
// Loader state encoding, default sync marker, checksum width.
package conv2d_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IFMAP  = 3'd1,
    ST_FILTER = 3'd2,
    ST_CSUM   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         CSUM_W        = 8;

endpackage

// File: rtl/conv2d_frame_loader_if.sv
// Received-byte stream from uart_rx into the frame loader.
// rx_data: byte, rx_valid: one-cycle strobe. master = uart, slave = loader.
interface conv2d_frame_loader_if;
  import conv2d_loader_pkg::*;

  logic [CSUM_W-1:0] rx_data;
  logic              rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input  rx_data, input  rx_valid);

endinterface

// File: rtl/loader_timeout_timer.sv
// Reloadable idle counter; expired pulses when the count reaches TIMEOUT_CYCLES-1.
// Ports: clk, rst_n, clear, enable, kick (reload), expired (comb pulse).
module loader_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A byte in the expiry cycle reloads the counter and wins over expiry.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    expired = 1'b0;
    if (clear || !enable || kick) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d   = '0;
      expired = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/conv2d_frame_loader.sv
// Framed loader: sync, ifmap stream to FIFO, filter shadow, checksum commit.
// Ports: clk, rst_n, clear_i, rx (byte stream), FIFO write/flush, filter, status.
module conv2d_frame_loader
  import conv2d_loader_pkg::*;
#(
  parameter int unsigned IFMAP_BYTES    = 1024,
  parameter int unsigned FILTER_BYTES   = 9,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_i,
  conv2d_frame_loader_if.slave      rx,
  output logic                      ifmap_wr_en_o,
  output logic [7:0]                ifmap_data_o,
  output logic                      fifo_flush_o,
  output logic [FILTER_BYTES*8-1:0] filter_data_o,
  output logic                      conv_en_o,
  output logic                      frame_err_o,
  output logic                      busy_o,
  output logic [7:0]                err_cnt_o
);

  localparam int unsigned BCW =
    (IFMAP_BYTES > 1) ? $clog2(IFMAP_BYTES) : 1;
  localparam int unsigned FW = FILTER_BYTES * 8;
  localparam logic [BCW-1:0] IFMAP_LAST = BCW'(IFMAP_BYTES - 1);
  localparam logic [BCW-1:0] FILT_LAST  = BCW'(FILTER_BYTES - 1);

  state_e            state_q, state_d;
  logic [BCW-1:0]    cnt_q, cnt_d;
  logic [CSUM_W-1:0] csum_q, csum_d;
  logic [FW-1:0]     shadow_q, shadow_d;
  logic [FW-1:0]     filter_q, filter_d;
  logic              conv_en_q, conv_en_d;
  logic              wr_en_q, wr_en_d;
  logic [7:0]        data_q, data_d;
  logic              flush_q, flush_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              in_frame;
  logic              expired;
  logic              fail;

  assign in_frame = (state_q == ST_IFMAP) ||
                    (state_q == ST_FILTER) ||
                    (state_q == ST_CSUM);

  loader_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear_i),
    .enable  (in_frame),
    .kick    (rx.rx_valid),
    .expired (expired)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    csum_d    = csum_q;
    shadow_d  = shadow_q;
    filter_d  = filter_q;
    conv_en_d = conv_en_q;
    wr_en_d   = 1'b0;
    data_d    = data_q;
    flush_d   = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    fail      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        csum_d = '0;
        if (rx.rx_valid && rx.rx_data == SYNC_BYTE)
          state_d = ST_IFMAP;
      end
      ST_IFMAP: begin
        if (rx.rx_valid) begin
          wr_en_d = 1'b1;
          data_d  = rx.rx_data;
          csum_d  = csum_q + rx.rx_data;
          if (cnt_q == IFMAP_LAST) begin
            cnt_d   = '0;
            state_d = ST_FILTER;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (expired) begin
          fail = 1'b1;
        end
      end
      ST_FILTER: begin
        if (rx.rx_valid) begin
          for (int k = 0; k < FILTER_BYTES; k++)
            if (cnt_q == BCW'(k))
              shadow_d[k*8 +: 8] = rx.rx_data;
          csum_d = csum_q + rx.rx_data;
          if (cnt_q == FILT_LAST) begin
            cnt_d   = '0;
            state_d = ST_CSUM;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (expired) begin
          fail = 1'b1;
        end
      end
      ST_CSUM: begin
        if (rx.rx_valid) begin
          if (rx.rx_data == csum_q) begin
            filter_d  = shadow_q;
            conv_en_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            fail = 1'b1;
          end
        end else if (expired) begin
          fail = 1'b1;
        end
      end
      ST_DONE: begin
      end
      default: state_d = ST_IDLE;
    endcase

    // Checksum mismatch and timeout share one abort path.
    if (fail) begin
      state_d  = ST_IDLE;
      err_d    = 1'b1;
      flush_d  = 1'b1;
      shadow_d = '0;
      cnt_d    = '0;
      csum_d   = '0;
      if (err_cnt_q != 8'hFF)
        err_cnt_d = err_cnt_q + 8'd1;
    end

    if (clear_i) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      csum_d    = '0;
      shadow_d  = '0;
      filter_d  = '0;
      conv_en_d = 1'b0;
      wr_en_d   = 1'b0;
      data_d    = '0;
      flush_d   = 1'b0;
      err_d     = 1'b0;
      err_cnt_d = '0;
    end

    busy_d = (state_d == ST_IFMAP) ||
             (state_d == ST_FILTER) ||
             (state_d == ST_CSUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      csum_q    <= '0;
      shadow_q  <= '0;
      filter_q  <= '0;
      conv_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      data_q    <= '0;
      flush_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      csum_q    <= csum_d;
      shadow_q  <= shadow_d;
      filter_q  <= filter_d;
      conv_en_q <= conv_en_d;
      wr_en_q   <= wr_en_d;
      data_q    <= data_d;
      flush_q   <= flush_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ifmap_wr_en_o = wr_en_q;
  assign ifmap_data_o  = data_q;
  assign fifo_flush_o  = flush_q;
  assign filter_data_o = filter_q;
  assign conv_en_o     = conv_en_q;
  assign frame_err_o   = err_q;
  assign busy_o        = busy_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: doc/conv2d_frame_loader.md
# conv2d_frame_loader

Framed-byte loader between `uart_rx` and `conv2d_top`. It parses a synchronised frame: sync byte, ifmap payload, filter payload, checksum. It streams ifmap bytes into the conv2d ifmap FIFO and stages filter bytes in a shadow register. It commits the filter and raises the convolution enable only when the checksum matches; otherwise it flushes the FIFO and flags an error.

## Interface
- `IFMAP_BYTES`, 1024, ifmap payload length in bytes.
- `FILTER_BYTES`, 9, filter payload length in bytes.
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `TIMEOUT_CYCLES`, 50_000_000, max idle cycles between bytes inside a frame.
- `clk` in 1 — system clock; one clock domain.
- `rst_n` in 1 — asynchronous, active-low reset.
- `clear_i` in 1 — synchronous clear, active-high; returns the block to post-reset state.
- `rx_data_i` in 8 — received byte.
- `rx_valid_i` in 1 — one-cycle strobe qualifying `rx_data_i`.
- `ifmap_wr_en_o` out 1 — ifmap FIFO write strobe.
- `ifmap_data_o` out 8 — ifmap FIFO write data.
- `fifo_flush_o` out 1 — one-cycle pulse; ifmap FIFO must be emptied.
- `filter_data_o` out FILTER_BYTES*8 — committed filter. Byte k sits at bits [(k+1)*8-1 -: 8], so the first received byte is in the LSBs.
- `conv_en_o` out 1 — level; high from frame acceptance until `clear_i`.
- `frame_err_o` out 1 — one-cycle pulse on checksum failure or timeout.
- `busy_o` out 1 — high while in any state other than IDLE or DONE.
- `err_cnt_o` out 8 — saturating count of `frame_err_o` pulses.

## Operation
- States: IDLE, IFMAP, FILTER, CSUM, DONE.
- **IDLE**
  - A byte equal to `SYNC_BYTE` moves to IFMAP.
  - Byte counter cleared; checksum accumulator cleared.
  - All other bytes are discarded.
- **IFMAP**
  - Each byte produces an `ifmap_wr_en_o` pulse with that byte on `ifmap_data_o`, and adds to the checksum.
  - After byte IFMAP_BYTES-1, counter resets and the state moves to FILTER.
- **FILTER**
  - Byte k is written into the shadow register (not `filter_data_o`) and added to the checksum.
  - After byte FILTER_BYTES-1, move to CSUM.
- **CSUM**
  - Received byte is compared with the checksum: 8-bit sum mod 256 of all payload bytes, sync excluded.
  - Match: copy shadow to `filter_data_o`, set `conv_en_o`, move to DONE.
  - Mismatch: pulse `frame_err_o` and `fifo_flush_o`, clear shadow, move to IDLE.
- **DONE**
  - All bytes ignored.
  - Exit only through `clear_i` or reset.
- **Timeout**
  - In IFMAP, FILTER or CSUM, an idle counter increments each cycle without `rx_valid_i`.
  - Reaching TIMEOUT_CYCLES-1 gives the same response as a checksum mismatch.
  - Counter reloads to 0 on every byte and in IDLE/DONE.
- Payload bytes equal to `SYNC_BYTE` are data, not resync.
- `err_cnt_o` saturates at 255; cleared only by reset or `clear_i`.

## Timing
- **Reset / clear values:** all outputs 0; state IDLE; shadow 0.
- **Simultaneous events:** `clear_i` overrides a concurrent `rx_valid_i`.
- **Registered outputs:** every output is registered.
  - `ifmap_wr_en_o` and `ifmap_data_o` appear 1 cycle after the qualifying `rx_valid_i`.
  - `conv_en_o`, the `filter_data_o` update, `frame_err_o` and `fifo_flush_o` appear 1 cycle after the checksum strobe, or 1 cycle after timeout expiry.
- **Byte throughput:** back-to-back `rx_valid_i` on consecutive cycles must be accepted without loss.
- **Byte vs timeout:** `rx_valid_i` in the cycle the timeout would expire counts as a byte; no timeout.
- **`filter_data_o` stability:** changes only on acceptance or clear, never mid-frame.
- **Reset mid-frame:** outputs are cleared immediately (asynchronous). No flush pulse is issued; a system reset also resets the FIFO.

## Structure
- Shared package `conv2d_loader_pkg` holds:
  - state encoding constants (IDLE..DONE);
  - default `SYNC_BYTE`;
  - checksum width localparam (8).
- Byte counter width: $clog2(IFMAP_BYTES).
- Idle counter width: $clog2(TIMEOUT_CYCLES).
- One sub-module: `loader_timeout_timer`, a reloadable idle counter with `kick` and `enable` inputs and an `expired` pulse output. FSM and datapath stay in the top.

## Test plan
- **Good frame:**
  - Stimulus: 0xA5, 1024 bytes i&0xFF, filter bytes 01..09, checksum (sum mod 256).
  - Response: 1024 writes in order; `filter_data_o` = 72'h090807060504030201; `conv_en_o` high; no error.
- **Bad checksum:** same frame with checksum+1 → `frame_err_o` and `fifo_flush_o` one pulse each, `filter_data_o` stays 0, `conv_en_o` low, `err_cnt_o`=1, state IDLE.
- **Leading noise / sync inside payload:** bytes 0x00, 0x5A, then a good frame whose ifmap contains 0xA5 → noise produces no writes; 0xA5 inside the payload is written as data; frame accepted.
- **Timeout:** TIMEOUT_CYCLES=100, sync plus 10 ifmap bytes then silence → error and flush exactly 100 cycles after the last byte. A byte arriving on cycle 99 prevents the timeout.
- **Clear vs strobe:** in DONE, assert `clear_i` with `rx_valid_i`=1, data 0xA5 → state IDLE, all outputs 0, the byte is not taken as sync. A following good frame is accepted.
- **Async reset mid-FILTER:** `rst_n` low for 3 cycles → outputs 0 immediately, no flush pulse. A subsequent good frame is accepted.
